sssp_dist_update_ctrl: RTL and testbench

- Read-modify-write controller for the per-vertex SSSP distance BRAM (1R/1W, registered read, 1-cycle read latency, read/write collisions undefined).
- Accepts streamed (vertex, candidate distance) updates from the gather pipeline at one per cycle and writes min(old, candidate) back.
- Forwards the previous write so that back-to-back updates to the same vertex are correct.
- Sweeps the whole memory to the INF sentinel on command and counts improvements so the iteration controller can detect convergence.

---
 rtl/sssp_pkg.sv | 20 ++
 rtl/sssp_fwd_reg.sv | 44 ++++
 rtl/sssp_dist_update_ctrl.sv | 130 +++++++++++++
 tb/tb_sssp_dist_update_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sssp_pkg.sv
// sssp_pkg: shared constants and FSM encoding for the SSSP distance
// read-modify-write controller.
//   DIST_W    - distance width (matches distance BRAM data width)
//   VTX_W     - vertex index width (BRAM depth is 2**VTX_W)
//   IMP_CNT_W - width of the improvement counter
//   INF_DIST  - "unreached" sentinel; equals the BRAM power-up value
package sssp_pkg;

  localparam int DIST_W    = 32;
  localparam int VTX_W     = 10;
  localparam int IMP_CNT_W = 16;

  localparam logic [DIST_W-1:0] INF_DIST = 32'h0000_ffdd;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/sssp_fwd_reg.sv
// sssp_fwd_reg: single-entry address/data forward register with hit compare.
// Holds the write issued in the previous cycle so the next read of the same
// address (which collides with that write at the BRAM) sees the new value.
//   clk, rst     - clock, synchronous active-high reset
//   flush        - drop the held entry
//   load         - capture load_addr/load_data; entry valid next cycle only
//   lookup_addr  - address compared against the held entry
//   hit, data    - held entry matches lookup_addr / held data
module sssp_fwd_reg
  import sssp_pkg::*;
#(
  parameter int ADDR_W = VTX_W,
  parameter int DATA_W = DIST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic              vld;
  logic [ADDR_W-1:0] addr_q;

  // Valid only for the cycle after a write; two-apart accesses read the BRAM.
  always_ff @(posedge clk) begin
    if (rst || flush) vld <= 1'b0;
    else              vld <= load;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      addr_q <= load_addr;
      data   <= load_data;
    end
  end

  assign hit = vld && (addr_q == lookup_addr);

endmodule

// File: rtl/sssp_dist_update_ctrl.sv
// sssp_dist_update_ctrl: read-modify-write controller for the per-vertex
// SSSP distance BRAM. Streams (vertex, candidate) updates at one per cycle,
// writes min(old, candidate), counts improvements, and sweeps the memory to
// INF_VAL on command.
//   clk, rst                  - clock, synchronous active-high reset
//   clear_start/busy/clear_done - clear sweep request / running / finished
//   upd_valid/upd_ready/upd_addr/upd_dist - update stream
//   bram_r_addr/bram_data_out - BRAM read port (1-cycle registered read)
//   bram_w_addr/bram_data_in/bram_we - BRAM write port
//   improve_cnt/improved      - saturating improvement count / count != 0
//
// state    | meaning
// ST_IDLE  | updates are processed
// ST_CLEAR | sweep writing INF_VAL to every address in progress
module sssp_dist_update_ctrl
  import sssp_pkg::*;
#(
  parameter int                DATA_W  = DIST_W,
  parameter int                ADDR_W  = VTX_W,
  parameter logic [DATA_W-1:0] INF_VAL = DATA_W'(INF_DIST),
  parameter int                CNT_W   = IMP_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_dist,
  output logic [ADDR_W-1:0] bram_r_addr,
  input  logic [DATA_W-1:0] bram_data_out,
  output logic [ADDR_W-1:0] bram_w_addr,
  output logic [DATA_W-1:0] bram_data_in,
  output logic              bram_we,
  output logic [CNT_W-1:0]  improve_cnt,
  output logic              improved
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH-1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   clr_cnt;  // one extra bit: DEPTH-1 ends the sweep without wrapping
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_dist;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] old_dist;
  logic              s1_write;
  logic              clr_last;
  logic              hs;

  assign upd_ready   = (state == ST_IDLE) && !clear_start && !rst;
  assign hs          = upd_valid && upd_ready;
  assign bram_r_addr = upd_addr;
  assign busy        = (state == ST_CLEAR);
  assign improved    = |improve_cnt;

  // The forwarded value covers the read that collided with last cycle's write.
  assign old_dist = fwd_hit ? fwd_data : bram_data_out;
  assign s1_write = s1_valid && (s1_dist < old_dist);
  assign clr_last = (state == ST_CLEAR) && (clr_cnt == LAST_ADDR);

  always_comb begin
    state_nxt    = state;
    bram_we      = 1'b0;
    bram_w_addr  = s1_addr;
    bram_data_in = s1_dist;
    case (state)
      ST_IDLE: begin
        bram_we = s1_write;
        if (clear_start) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Reset aborts the sweep before the current address is written.
        bram_we      = !rst;
        bram_w_addr  = clr_cnt[ADDR_W-1:0];
        bram_data_in = INF_VAL;
        if (clr_cnt == LAST_ADDR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      clr_cnt     <= '0;
      s1_valid    <= 1'b0;
      clear_done  <= 1'b0;
      improve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      s1_valid   <= hs;
      clear_done <= clr_last;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                   clr_cnt <= '0;
      if (clr_last)
        improve_cnt <= '0;
      else if (s1_write && !(&improve_cnt))
        improve_cnt <= improve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      s1_addr <= upd_addr;
      s1_dist <= upd_dist;
    end
  end

  sssp_fwd_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd (
    .clk         (clk),
    .rst         (rst),
    .flush       (clr_last),
    .load        (s1_write),
    .load_addr   (s1_addr),
    .load_data   (s1_dist),
    .lookup_addr (s1_addr),
    .hit         (fwd_hit),
    .data        (fwd_data)
  );

endmodule

// File: tb/tb_sssp_dist_update_ctrl.sv
// Self-checking bench for sssp_dist_update_ctrl: behavioural BRAM, a
// reference distance array model checked every cycle, and directed tests.
module tb_sssp_dist_update_ctrl;
  localparam int          AW    = 10;
  localparam int          DW    = 32;
  localparam int          CW    = 16;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] INF   = 32'h0000_ffdd;

  logic          clk = 1'b0;
  logic          rst, clear_start, busy, clear_done;
  logic          upd_valid, upd_ready;
  logic [AW-1:0] upd_addr, bram_r_addr, bram_w_addr;
  logic [DW-1:0] upd_dist, bram_data_out, bram_data_in;
  logic          bram_we, improved;
  logic [CW-1:0] improve_cnt;

  always #5 clk = ~clk;

  sssp_dist_update_ctrl dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .busy(busy),
    .clear_done(clear_done), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_addr(upd_addr), .upd_dist(upd_dist), .bram_r_addr(bram_r_addr),
    .bram_data_out(bram_data_out), .bram_w_addr(bram_w_addr),
    .bram_data_in(bram_data_in), .bram_we(bram_we),
    .improve_cnt(improve_cnt), .improved(improved)
  );

  // Behavioural BRAM: registered read, read-before-write on collision.
  logic [31:0] ram [DEPTH] = '{default: INF};
  always @(posedge clk) begin
    if (bram_we === 1'b1) ram[bram_w_addr] <= bram_data_in;
    bram_data_out <= ram[bram_r_addr];
  end

  int errors = 0, checks = 0, wr_count = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: logical distance per vertex plus the expected write
  // for the current cycle.
  logic [31:0] ref_mem [DEPTH] = '{default: INF};
  bit          m_clearing = 0, m_done = 0, m_pend = 0;
  int          m_clr_idx = 0, m_cnt = 0;
  logic [31:0] m_pa = 0, m_pd = 0;
  bit          e_ready, e_we, hs_m, nd;

  always @(negedge clk) begin
    e_ready = !m_clearing && !clear_start && !rst;
    e_we    = m_clearing ? !rst : m_pend;
    if (started) begin
      chk("upd_ready", upd_ready, e_ready);
      chk("busy", busy, m_clearing);
      chk("clear_done", clear_done, m_done);
      chk("improve_cnt", improve_cnt, m_cnt);
      chk("improved", improved, m_cnt != 0);
      chk("bram_we", bram_we, e_we);
      if (e_we) begin
        chk("bram_w_addr", bram_w_addr, m_clearing ? m_clr_idx : m_pa);
        chk("bram_data_in", bram_data_in, m_clearing ? INF : m_pd);
      end
      if (upd_valid) chk("bram_r_addr", bram_r_addr, upd_addr);
    end
    if (bram_we === 1'b1) wr_count++;
    if (rst) begin
      m_clearing = 0; m_done = 0; m_cnt = 0; m_pend = 0;
    end else begin
      nd = m_clearing && (m_clr_idx == DEPTH-1);
      if (m_pend && m_cnt < 65535) m_cnt++;
      hs_m   = e_ready && upd_valid;
      m_pend = 0;
      if (hs_m && upd_dist < ref_mem[upd_addr]) begin
        ref_mem[upd_addr] = upd_dist;
        m_pend = 1; m_pa = upd_addr; m_pd = upd_dist;
      end
      if (m_clearing) begin
        ref_mem[m_clr_idx] = INF;
        if (m_clr_idx == DEPTH-1) begin m_clearing = 0; m_cnt = 0; end
        else m_clr_idx++;
      end else if (clear_start) begin
        m_clearing = 1; m_clr_idx = 0;
      end
      m_done = nd;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic upd(input int a, input int d);
    step();
    upd_valid = 1'b1; upd_addr = AW'(a); upd_dist = DW'(d);
  endtask

  task automatic idle(input int n);
    step();
    upd_valid = 1'b0; clear_start = 1'b0;
    repeat (n) step();
  endtask

  // Called in the first sweep cycle; n counts cycles since clear_start.
  task automatic wait_done(output int n);
    n = 1;
    while (n < DEPTH + 20) begin
      @(negedge clk);
      if (clear_done === 1'b1) break;
      step();
      n++;
    end
  endtask

  int n, w0, bad;

  initial begin
    rst = 1'b1; clear_start = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_dist = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; started = 1'b1;
    @(negedge clk);
    chk("reset_cnt", improve_cnt, 0);
    chk("reset_busy", busy, 0);

    // 1: clear then single update
    step(); clear_start = 1'b1;
    step(); clear_start = 1'b0;
    wait_done(n);
    chk("t1_clear_latency", n, DEPTH + 1);
    w0 = wr_count;
    upd(5, 100); idle(3);
    chk("t1_writes", wr_count - w0, 1);
    chk("t1_ram5", ram[5], 100);
    chk("t1_cnt", improve_cnt, 1);

    // 2: non-improving updates
    w0 = wr_count;
    upd(5, 100); upd(5, 150); idle(3);
    chk("t2_writes", wr_count - w0, 0);
    chk("t2_ram5", ram[5], 100);
    chk("t2_cnt", improve_cnt, 1);

    // 3: back-to-back same vertex
    w0 = wr_count;
    upd(7, 50); upd(7, 60); upd(7, 40); idle(3);
    chk("t3_writes", wr_count - w0, 2);
    chk("t3_ram7", ram[7], 40);
    chk("t3_cnt", improve_cnt, 3);
    chk("t3_model_ram7", ref_mem[7], 40);

    // 4: interleaved addresses
    w0 = wr_count;
    upd(3, 10); upd(4, 20); upd(3, 5); idle(3);
    chk("t4_writes", wr_count - w0, 3);
    chk("t4_ram3", ram[3], 5);
    chk("t4_ram4", ram[4], 20);
    chk("t4_cnt", improve_cnt, 6);

    // 5: clear contention with a held update
    upd(8, 11);
    step(); upd_addr = AW'(9); upd_dist = DW'(33); clear_start = 1'b1;
    @(negedge clk);
    chk("t5_ready_at_start", upd_ready, 0);
    step(); clear_start = 1'b0;
    chk("t5_inflight_ram8", ram[8], 11);
    wait_done(n);
    chk("t5_clear_latency", n, DEPTH + 1);
    chk("t5_cnt_after_clear", improve_cnt, 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== INF) bad++;
    chk("t5_all_inf", bad, 0);
    idle(3);
    chk("t5_held_ram9", ram[9], 33);
    chk("t5_cnt_held", improve_cnt, 1);

    // 6: reset at sweep address 100
    upd(99, 7); upd(100, 8); upd(101, 9); idle(3);
    chk("t6_cnt_pre", improve_cnt, 4);
    step(); clear_start = 1'b1;
    step(); clear_start = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_cnt_after_rst", improve_cnt, 0);
    idle(20);
    chk("t6_ram0", ram[0], INF);
    chk("t6_ram99", ram[99], INF);
    chk("t6_ram100", ram[100], 8);
    chk("t6_ram101", ram[101], 9);
    chk("t6_model_ram100", ref_mem[100], 8);
    upd(100, 3); idle(3);
    chk("t6_post_ram100", ram[100], 3);
    chk("t6_post_cnt", improve_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
